// File: rtl/ldpc_frame_ctrl_if.sv
// Frame-in / result-out handshake bundle for the LDPC frame sequencer.
// master = upstream source + downstream sink side, slave = the sequencer.
interface ldpc_frame_ctrl_if #(
  parameter int N      = 576,
  parameter int data_w = 8,
  parameter int ITER_W = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [N*data_w-1:0]   in_llr;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0]          out_bits;
  logic                  out_err;
  logic [ITER_W-1:0]     out_iters;

  modport master (
    output in_valid, in_llr, out_ready,
    input  in_ready, out_valid, out_bits, out_err, out_iters
  );

  modport slave (
    input  in_valid, in_llr, out_ready,
    output in_ready, out_valid, out_bits, out_err, out_iters
  );
endinterface

// File: rtl/ldpc_frame_ctrl.sv
// QC-LDPC frame sequencer: one-frame input buffer, load/iterate/report FSM
// around the CNU/VNU core, registered valid/ready result slot.
module ldpc_frame_ctrl #(
  parameter int data_w   = 8,
  parameter int R        = 24,
  parameter int D        = 24,
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 128,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ldpc_frame_ctrl_if.slave        io,
  output logic                    dec_load,
  output logic                    dec_run,
  output logic [R*D*data_w-1:0]   dec_llr,
  input  logic [R*D-1:0]          dec_bits,
  input  logic                    dec_check,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic                    busy
);
  localparam int N = R*D;
  localparam logic [ITER_W-1:0] LAST  = ITER_W'(MAX_ITER-1);
  localparam logic [ITER_W-1:0] LIMIT = ITER_W'(MAX_ITER);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t              state;
  logic                buf_full;
  logic [N*data_w-1:0] buf_llr;
  logic [ITER_W-1:0]   iter_cnt;
  logic [N-1:0]        stg_bits;
  logic                stg_err;
  logic [ITER_W-1:0]   stg_iters;

  assign io.in_ready = ~buf_full;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      buf_full     <= 1'b0;
      buf_llr      <= '0;
      iter_cnt     <= '0;
      stg_bits     <= '0;
      stg_err      <= 1'b0;
      stg_iters    <= '0;
      dec_load     <= 1'b0;
      dec_run      <= 1'b0;
      dec_llr      <= '0;
      fail_cnt     <= '0;
      io.out_valid <= 1'b0;
      io.out_bits  <= '0;
      io.out_err   <= 1'b0;
      io.out_iters <= '0;
    end else begin
      if (io.in_valid && !buf_full) begin
        buf_llr  <= io.in_llr;
        buf_full <= 1'b1;
      end
      // Consumed result drops valid; a DONE reload below overrides this.
      if (io.out_valid && io.out_ready)
        io.out_valid <= 1'b0;
      dec_load <= 1'b0;

      case (state)
        IDLE: if (buf_full) begin
          state    <= LOAD;
          dec_load <= 1'b1;
          dec_llr  <= buf_llr;
        end
        LOAD: begin
          buf_full <= 1'b0;
          state    <= ITER;
          dec_run  <= 1'b1;
          iter_cnt <= '0;
        end
        ITER: begin
          // A parity pass wins over the limit, even on the last allowed cycle.
          if (dec_check) begin
            stg_bits  <= dec_bits;
            stg_err   <= 1'b0;
            stg_iters <= iter_cnt;
            dec_run   <= 1'b0;
            state     <= DONE;
          end else if (iter_cnt == LAST) begin
            stg_bits  <= dec_bits;
            stg_err   <= 1'b1;
            stg_iters <= LIMIT;
            dec_run   <= 1'b0;
            state     <= DONE;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        DONE: if (!io.out_valid || io.out_ready) begin
          io.out_valid <= 1'b1;
          io.out_bits  <= stg_bits;
          io.out_err   <= stg_err;
          io.out_iters <= stg_iters;
          if (stg_err && (fail_cnt != {CNT_W{1'b1}}))
            fail_cnt <= fail_cnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ldpc_frame_ctrl.sv
// Randomized scoreboard bench for ldpc_frame_ctrl with a behavioural core model;
// a second small instance covers failed-frame counter saturation.
module tb_ldpc_frame_ctrl;
  localparam int DW   = 8;
  localparam int R    = 24;
  localparam int D    = 24;
  localparam int N    = R*D;
  localparam int W    = N*DW;
  localparam int IW   = 8;
  localparam int MAXI = 128;
  localparam int CW   = 16;
  localparam int SN   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] bits;
    logic         err;
    logic [IW-1:0] iters;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_fail = 0;
  int   rdy_mode = 1;

  // main DUT
  ldpc_frame_ctrl_if #(.N(N), .data_w(DW), .ITER_W(IW)) m_if ();
  logic          dec_load, dec_run, dec_check, busy;
  logic [W-1:0]  dec_llr;
  logic [N-1:0]  dec_bits;
  logic [CW-1:0] fail_cnt;

  ldpc_frame_ctrl #(.data_w(DW), .R(R), .D(D), .ITER_W(IW), .MAX_ITER(MAXI), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .io(m_if.slave),
    .dec_load(dec_load), .dec_run(dec_run), .dec_llr(dec_llr),
    .dec_bits(dec_bits), .dec_check(dec_check),
    .fail_cnt(fail_cnt), .busy(busy)
  );

  // saturation DUT: tiny frame, 2 iterations, 2-bit counter, core never passes
  ldpc_frame_ctrl_if #(.N(SN), .data_w(DW), .ITER_W(IW)) s_if ();
  logic           s_load, s_run, s_busy;
  logic [SN*DW-1:0] s_llr;
  logic [1:0]     s_fail;

  ldpc_frame_ctrl #(.data_w(DW), .R(1), .D(SN), .ITER_W(IW), .MAX_ITER(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .io(s_if.slave),
    .dec_load(s_load), .dec_run(s_run), .dec_llr(s_llr),
    .dec_bits(8'hA5), .dec_check(1'b0),
    .fail_cnt(s_fail), .busy(s_busy)
  );

  // Core model: the pass iteration is carried in LLR slot 0 of the frame;
  // hard decisions are LLR signs XOR the current iteration index.
  logic [W-1:0] core_llr;
  logic [7:0]   core_k, core_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_llr <= '0; core_k <= '0; core_p <= '0;
    end else if (dec_load) begin
      core_llr <= dec_llr; core_k <= '0; core_p <= dec_llr[7:0];
    end else if (dec_run) begin
      core_k <= core_k + 8'd1;
    end
  end

  always_comb begin
    dec_bits = '0;
    for (int i = 0; i < N; i++) dec_bits[i] = core_llr[i*DW+DW-1] ^ core_k[i%8];
  end
  assign dec_check = (core_k == core_p);

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference: pass at p if p < MAXI, otherwise run out at MAXI iterations.
  function automatic res_t model(input logic [W-1:0] f);
    res_t r;
    int p, fin;
    p   = int'(f[7:0]);
    fin = (p < MAXI) ? p : MAXI-1;
    r.err   = (p >= MAXI);
    r.iters = r.err ? IW'(MAXI) : IW'(p);
    for (int i = 0; i < N; i++) r.bits[i] = f[i*DW+DW-1] ^ ((fin >> (i%8)) & 1);
    return r;
  endfunction

  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       m_if.out_ready = 1'b0;
      1:       m_if.out_ready = 1'b1;
      default: m_if.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: scoreboard pop on every output transfer, plus dec_run burst length.
  int   run_cnt = 0;
  logic run_d = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); exp_fail = 0; run_cnt = 0; run_d = 1'b0;
    end else begin
      if (m_if.out_valid && m_if.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got iters %0d with empty scoreboard", m_if.out_iters);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          if (e.err) exp_fail++;
          check("out_bits", m_if.out_bits, e.bits);
          check("out_err", N'(m_if.out_err), N'(e.err));
          check("out_iters", N'(m_if.out_iters), N'(e.iters));
          check("fail_cnt", N'(fail_cnt), N'(exp_fail));
        end
      end
      if (dec_run) run_cnt++;
      if (run_d && !dec_run) begin
        int fin;
        fin = (int'(core_p) < MAXI) ? int'(core_p) : MAXI-1;
        check("run_cycles", N'(run_cnt), N'(fin + 1));
        run_cnt = 0;
      end
      run_d = dec_run;
    end
  end

  function automatic logic [W-1:0] mk_frame(input int p);
    logic [W-1:0] f;
    for (int i = 0; i < W/32; i++) f[i*32 +: 32] = $urandom();
    f[7:0] = 8'(p);
    return f;
  endfunction

  task automatic send(input logic [W-1:0] f);
    @(posedge clk); #1;
    m_if.in_valid = 1'b1;
    m_if.in_llr   = f;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (m_if.in_ready) begin
        exp_q.push_back(model(f));
        @(posedge clk); #1;
        m_if.in_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL send_timeout: in_ready stayed %0d", m_if.in_ready);
    m_if.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !m_if.out_valid) break;
    end
    check("drain", N'(exp_q.size()), N'(0));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_ready"}, N'(m_if.in_ready), N'(1));
    check({tag, "_out_valid"}, N'(m_if.out_valid), N'(0));
    check({tag, "_busy"}, N'(busy), N'(0));
    check({tag, "_dec_run"}, N'({dec_run, dec_load}), N'(0));
    check({tag, "_fail_cnt"}, N'(fail_cnt), N'(0));
    check({tag, "_out_iters"}, N'({m_if.out_err, m_if.out_iters}), N'(0));
    check({tag, "_dec_llr_lo"}, dec_llr[N-1:0], N'(0));
  endtask

  initial begin
    int c, k;
    rst_n = 1'b0;
    m_if.in_valid = 1'b0; m_if.in_llr = '0;
    s_if.in_valid = 1'b0; s_if.in_llr = '0; s_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst_n = 1'b1;

    // 1: pass at iteration 0, latency to out_valid
    send(mk_frame(0));
    c = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m_if.out_valid) begin c = i; break; end
    end
    check("latency", N'(c), N'(5));
    drain();

    // 2, 3: pass at 17; never pass
    send(mk_frame(17)); drain();
    send(mk_frame(200)); drain();
    check("fail_cnt_after_fail", N'(fail_cnt), N'(1));

    // 4: three frames back to back with the sink stalled
    rdy_mode = 0;
    send(mk_frame(2)); send(mk_frame(5)); send(mk_frame(0));
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("stall_in_ready", N'(m_if.in_ready), N'(0));
    check("stall_busy", N'(busy), N'(1));
    check("stall_out_valid", N'({m_if.out_valid, dec_run}), N'(2'b10));
    rdy_mode = 1;
    drain();

    // random traffic, random sink backpressure
    rdy_mode = 2;
    for (int n = 0; n < 25; n++) begin
      send(mk_frame(($urandom_range(0, 7) == 0) ? $urandom_range(MAXI-1, 255) : $urandom_range(0, 23)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    drain();
    rdy_mode = 1;

    // 5: reset during ITER at iteration 40 with a second frame buffered
    send(mk_frame(255));
    send(mk_frame(3));
    k = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (dec_run && core_k == 8'd40) begin k = 1; break; end
    end
    check("reached_iter40", N'(k), N'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_stale_output", N'({m_if.out_valid, busy}), N'(0));
    send(mk_frame(5)); drain();

    // 6: saturating counter on the small instance
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      s_if.in_valid = 1'b1;
      s_if.in_llr   = {$urandom(), $urandom()};
      k = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (s_if.in_ready && s_if.in_valid) begin
          @(posedge clk); #1 s_if.in_valid = 1'b0;
        end
        if (s_if.out_valid) begin k = 1; break; end
      end
      s_if.in_valid = 1'b0;
      check("sat_out_valid", N'(k), N'(1));
      check("sat_out_err", N'({s_if.out_err, s_if.out_iters}), N'({1'b1, 8'd2}));
      check("sat_out_bits", N'(s_if.out_bits), N'(8'hA5));
      check("sat_fail_cnt", N'(s_fail), N'((n < 3) ? n : 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
